mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified instruction/data memory between the IF stage (fetch) and
//  the MEM stage (loads/stores driven by MemRead/MemWrite from the control unit).
//  Sequences each access over a fixed-latency memory. Gives data accesses priority.
//  Generates the stall signals that freeze the pipeline while a requester waits.
// PARAMETERS
//  ADDR_W   32  address width (byte address)
//  DATA_W   32  data width
//  MEM_LAT  2   cycles from issue edge to mem_rdata valid; legal range 1..15
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       reset, synchronous, active-high
//  if_req     in   1       fetch request; held with if_addr until if_valid
//  if_addr    in   ADDR_W  fetch address
//  if_kill    in   1       discard in-flight/pending fetch (branch/jump redirect)
//  if_rdata   out  DATA_W  fetched instruction, valid with if_valid
//  if_valid   out  1       one-cycle completion pulse for fetch
//  d_req      in   1       data request (MemRead|MemWrite); held stable until d_valid
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_be       in   DATA_W/8 store byte enables
//  d_rdata    out  DATA_W  load data, valid with d_valid
//  d_valid    out  1       one-cycle completion pulse for data (loads and stores)
//  mem_en     out  1       memory access strobe (one cycle per access)
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_be     out  DATA_W/8 memory byte enables
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after issue
//  stall_if   out  1       = if_req & ~if_valid
//  stall_mem  out  1       = d_req & ~d_valid
// BEHAVIOUR
//  - FSM states: IDLE, BUSY_D, BUSY_IF; 4-bit down-counter cnt.
//  - IDLE:
//      - d_req: issue data access, next state BUSY_D.
//      - else if_req & ~if_kill: issue fetch, next state BUSY_IF.
//      - else stay in IDLE.
//  - Issue is combinational in IDLE:
//      - mem_en = 1; mem_addr/we/wdata/be taken from the winner; cnt <= MEM_LAT-1.
//      - Fetch issue forces mem_we = 0 and mem_be = 0.
//  - Outside an issue cycle:
//      - mem_en = 0 and mem_we = 0.
//      - mem_addr/wdata/be are don't-care; drive 0.
//  - BUSY_x with cnt != 0: cnt decrements; no issue.
//  - BUSY_x with cnt == 0 (completion cycle):
//      - mem_rdata is captured into d_rdata (loads only) or if_rdata.
//      - Next state is IDLE.
//      - x_valid pulses high in the following cycle.
//  - Latency: issue in cycle T gives x_valid in cycle T+MEM_LAT+1.
//    Next issue can be in that same cycle. Throughput is 1 access per MEM_LAT+1 cycles.
//  - Stores complete with a d_valid pulse; d_rdata keeps its previous value.
//  - Requests are sampled only in IDLE. A request raised during BUSY waits; no queueing.
//  - Fixed priority: data > fetch. A simultaneous d_req & if_req in IDLE issues data.
//    Fetch issues in the first IDLE cycle after d_valid if d_req is then low.
//  - if_kill:
//      - In IDLE: blocks fetch issue that cycle.
//      - In BUSY_IF, or on the cycle if_valid would pulse: suppress if_valid for that access.
//        if_rdata may still update.
//      - No effect on data accesses.
//  - x_valid is a registered pulse. stall_* are combinational from x_req and registered x_valid.
//  - if_rdata/d_rdata hold their value between completions.
//  - Reset (any state, including mid-access):
//      - Outputs: state = IDLE, cnt = 0, if_valid = d_valid = 0, if_rdata = d_rdata = 0,
//        mem_en = 0 in the reset cycle.
//      - The in-flight memory response is ignored.
//      - The first issue can occur in the cycle after rst deasserts.
// TESTING (MEM_LAT=2 unless noted)
//  1. Single load, d_addr=0x40, mem returns 0xDEADBEEF:
//     -> mem_en=1 in cycle 0 only; d_valid in cycle 3 with d_rdata=0xDEADBEEF;
//        stall_mem=1 in cycles 0-2 and 0 in cycle 3.
//  2. if_req & d_req together in IDLE:
//     -> data issued in cycle 0, d_valid in cycle 3; fetch issued in cycle 3, if_valid in cycle 6;
//        stall_if high in cycles 0-5.
//  3. Store, d_wdata=0x12345678, d_be=4'b0011:
//     -> mem_en=mem_we=1, mem_be=0011 in the issue cycle; d_valid 3 cycles later;
//        d_rdata unchanged.
//  4. Fetch issued, if_kill pulsed in cycle 1:
//     -> no if_valid for that fetch; a new if_req issues in cycle 3.
//  5. rst asserted in cycle 1 of a load:
//     -> next cycle all outputs at reset values; no d_valid; a new load after deassert
//        completes normally.
//  6. MEM_LAT=1, back-to-back fetches held high:
//     -> mem_en every 2nd cycle; if_valid in cycles 2, 4, 6, ... with correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and data access.
// Data wins over fetch; each access owns the port for MEM_LAT+1 cycles.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_kill,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if,
   output logic                stall_mem
);

   localparam int unsigned BE_W = DATA_W / 8;
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {StIdle, StBusyD, StBusyIf} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              kill_q, kill_d;
   logic              load_q, load_d;
   logic              if_valid_q, if_valid_d;
   logic              d_valid_q, d_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      kill_d     = kill_q;
      load_d     = load_q;
      if_valid_d = 1'b0;
      d_valid_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = '0;

      unique case (state_q)
         StIdle: begin
            if (d_req) begin
               mem_en    = 1'b1;
               mem_we    = d_we;
               mem_addr  = d_addr;
               mem_wdata = d_wdata;
               mem_be    = d_be;
               load_d    = ~d_we;
               cnt_d     = LAT_M1;
               state_d   = StBusyD;
            end else if (if_req && !if_kill) begin
               mem_en   = 1'b1;
               mem_addr = if_addr;
               kill_d   = 1'b0;
               cnt_d    = LAT_M1;
               state_d  = StBusyIf;
            end
         end
         StBusyD: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (load_q) d_rdata_d = mem_rdata;
               d_valid_d = 1'b1;
               state_d   = StIdle;
            end
         end
         StBusyIf: begin
            if (if_kill) kill_d = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // A redirect seen at any point during the access drops its completion.
               if_rdata_d = mem_rdata;
               if_valid_d = ~(kill_q | if_kill);
               kill_d     = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (rst) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         mem_be    = {BE_W{1'b0}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         kill_q     <= 1'b0;
         load_q     <= 1'b0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         kill_q     <= kill_d;
         load_q     <= load_d;
         if_valid_q <= if_valid_d;
         d_valid_q  <= d_valid_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // A kill arriving in the pulse cycle still cancels the completion.
   assign if_valid  = if_valid_q & ~if_kill;
   assign d_valid   = d_valid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for most scenarios,
// MEM_LAT=1 instance for back-to-back fetch throughput.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem;
   logic [3:0]  mem_be;

   logic        if_req1;
   logic [31:0] if_addr1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_valid1, d_valid1, mem_en1, mem_we1, stall_if1, stall_mem1;
   logic [3:0]  mem_be1;

   logic [31:0] pa2_0, pa2_1, pa1_0;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: address seen at issue returns data MEM_LAT cycles later.
   always @(posedge clk) begin
      pa2_0 <= mem_addr;
      pa2_1 <= pa2_0;
      pa1_0 <= mem_addr1;
   end
   assign mem_rdata  = memf(pa2_1);
   assign mem_rdata1 = memf(pa1_0);

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_kill(1'b0),
      .if_rdata(if_rdata1), .if_valid(if_valid1),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
      .d_rdata(d_rdata1), .d_valid(d_valid1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_be(mem_be1), .mem_rdata(mem_rdata1),
      .stall_if(stall_if1), .stall_mem(stall_mem1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      d_req = 1'b1;
      #1;
      vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      vecs++; if (d_valid !== 1'b0 || if_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got d=%b if=%b want 0 0", d_valid, if_valid); end
      vecs++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got d=%h if=%h want 0 0", d_rdata, if_rdata); end
      d_req = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_single_load();
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin errs++; $display("FAIL load_issue: got en=%b we=%b addr=%h want 1 0 00000040", mem_en, mem_we, mem_addr); end
      vecs++; if (stall_mem !== 1'b1) begin errs++; $display("FAIL load_stall_c0: got %b want 1", stall_mem); end
      for (int c = 1; c <= 2; c++) begin
         tick();
         vecs++; if (d_valid !== 1'b0) begin errs++; $display("FAIL load_early_valid c%0d: got %b want 0", c, d_valid); end
         #1;
         vecs++; if (mem_en !== 1'b0 || stall_mem !== 1'b1) begin errs++; $display("FAIL load_busy c%0d: got en=%b stall=%b want 0 1", c, mem_en, stall_mem); end
      end
      tick();
      vecs++; if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL load_done: got v=%b data=%h want 1 deadbeef", d_valid, d_rdata); end
      vecs++; if (stall_mem !== 1'b0) begin errs++; $display("FAIL load_stall_c3: got %b want 0", stall_mem); end
      d_req = 1'b0;
      tick();
      vecs++; if (d_valid !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL load_hold: got v=%b data=%h want 0 deadbeef", d_valid, d_rdata); end
   endtask

   task automatic test_priority();
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      if_req = 1'b1; if_addr = 32'h200;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin errs++; $display("FAIL prio_data_first: got en=%b addr=%h want 1 00000100", mem_en, mem_addr); end
      vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL prio_stall_if_c0: got %b want 1", stall_if); end
      for (int c = 1; c <= 2; c++) begin
         tick(); #1;
         vecs++; if (stall_if !== 1'b1 || mem_en !== 1'b0) begin errs++; $display("FAIL prio_wait c%0d: got stall=%b en=%b want 1 0", c, stall_if, mem_en); end
      end
      tick();
      vecs++; if (d_valid !== 1'b1 || d_rdata !== 32'h0100FEFF) begin errs++; $display("FAIL prio_data_done: got v=%b data=%h want 1 0100feff", d_valid, d_rdata); end
      d_req = 1'b0;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0 || mem_be !== 4'h0) begin errs++; $display("FAIL prio_fetch_issue: got en=%b addr=%h we=%b be=%h want 1 00000200 0 0", mem_en, mem_addr, mem_we, mem_be); end
      vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL prio_stall_if_c3: got %b want 1", stall_if); end
      for (int c = 4; c <= 5; c++) begin
         tick(); #1;
         vecs++; if (stall_if !== 1'b1 || if_valid !== 1'b0) begin errs++; $display("FAIL prio_fetch_wait c%0d: got stall=%b v=%b want 1 0", c, stall_if, if_valid); end
      end
      tick();
      vecs++; if (if_valid !== 1'b1 || if_rdata !== 32'h0200FDFF || stall_if !== 1'b0) begin errs++; $display("FAIL prio_fetch_done: got v=%b data=%h stall=%b want 1 0200fdff 0", if_valid, if_rdata, stall_if); end
      if_req = 1'b0;
      tick();
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL prio_fetch_pulse: got %b want 0", if_valid); end
   endtask

   task automatic test_store();
      tick();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678; d_be = 4'b0011;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h300) begin
         errs++; $display("FAIL store_issue: got en=%b we=%b be=%b wd=%h addr=%h want 1 1 0011 12345678 00000300", mem_en, mem_we, mem_be, mem_wdata, mem_addr); end
      tick(); #1;
      vecs++; if (mem_we !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL store_we_drop: got en=%b we=%b want 0 0", mem_en, mem_we); end
      tick();
      tick();
      vecs++; if (d_valid !== 1'b1 || d_rdata !== 32'h0100FEFF) begin errs++; $display("FAIL store_done: got v=%b data=%h want 1 0100feff", d_valid, d_rdata); end
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
   endtask

   task automatic test_kill();
      tick();
      if_req = 1'b1; if_addr = 32'h400;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h400) begin errs++; $display("FAIL kill_issue: got en=%b addr=%h want 1 00000400", mem_en, mem_addr); end
      tick();
      if_kill = 1'b1; if_addr = 32'h800;
      #1;
      vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL kill_busy_en: got %b want 0", mem_en); end
      tick();
      if_kill = 1'b0;
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL kill_c2_valid: got %b want 0", if_valid); end
      tick();
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL kill_suppressed: got %b want 0", if_valid); end
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h800) begin errs++; $display("FAIL kill_reissue: got en=%b addr=%h want 1 00000800", mem_en, mem_addr); end
      tick();
      tick();
      tick();
      vecs++; if (if_valid !== 1'b1 || if_rdata !== 32'h0800F7FF) begin errs++; $display("FAIL kill_refetch_done: got v=%b data=%h want 1 0800f7ff", if_valid, if_rdata); end
      if_req = 1'b0;
   endtask

   task automatic test_kill_edges();
      tick();
      if_req = 1'b1; if_addr = 32'h500; if_kill = 1'b1;
      #1;
      vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL kill_idle_block: got %b want 0", mem_en); end
      if_kill = 1'b0;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h500) begin errs++; $display("FAIL kill_idle_release: got en=%b addr=%h want 1 00000500", mem_en, mem_addr); end
      tick();
      tick();
      tick();
      if_kill = 1'b1;
      #1;
      vecs++; if (if_valid !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL kill_pulse_cycle: got v=%b en=%b want 0 0", if_valid, mem_en); end
      if_kill = 1'b0; if_req = 1'b0;
      tick();
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL kill_after_pulse: got %b want 0", if_valid); end
   endtask

   task automatic test_reset_mid();
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      #1;
      vecs++; if (mem_en !== 1'b1) begin errs++; $display("FAIL rstmid_issue: got %b want 1", mem_en); end
      tick();
      rst = 1'b1; d_req = 1'b0;
      #1;
      vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL rstmid_en: got %b want 0", mem_en); end
      tick();
      rst = 1'b0;
      vecs++; if (d_valid !== 1'b0 || if_valid !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
         errs++; $display("FAIL rstmid_outputs: got dv=%b iv=%b dd=%h id=%h want 0 0 0 0", d_valid, if_valid, d_rdata, if_rdata); end
      #1;
      vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL rstmid_idle_en: got %b want 0", mem_en); end
      tick();
      vecs++; if (d_valid !== 1'b0) begin errs++; $display("FAIL rstmid_no_valid: got %b want 0", d_valid); end
      d_req = 1'b1; d_addr = 32'h80;
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin errs++; $display("FAIL rstmid_new_issue: got en=%b addr=%h want 1 00000080", mem_en, mem_addr); end
      tick();
      tick();
      tick();
      vecs++; if (d_valid !== 1'b1 || d_rdata !== 32'h0080FF7F) begin errs++; $display("FAIL rstmid_new_done: got v=%b data=%h want 1 0080ff7f", d_valid, d_rdata); end
      d_req = 1'b0;
   endtask

   task automatic test_back_to_back_lat1();
      logic [31:0] addrs [3];
      logic [31:0] datas [3];
      addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h1008;
      datas[0] = 32'h1000EFFF; datas[1] = 32'h1004EFFB; datas[2] = 32'h1008EFF7;
      tick();
      if_req1 = 1'b1; if_addr1 = addrs[0];
      #1;
      vecs++; if (mem_en1 !== 1'b1 || mem_addr1 !== addrs[0] || mem_be1 !== 4'h0 || mem_wdata1 !== 32'h0 || mem_we1 !== 1'b0) begin
         errs++; $display("FAIL b2b_issue0: got en=%b addr=%h be=%h wd=%h we=%b want 1 %h 0 0 0", mem_en1, mem_addr1, mem_be1, mem_wdata1, mem_we1, addrs[0]); end
      for (int k = 0; k < 3; k++) begin
         tick();
         vecs++; if (if_valid1 !== 1'b0 || stall_if1 !== 1'b1) begin errs++; $display("FAIL b2b_busy k%0d: got v=%b stall=%b want 0 1", k, if_valid1, stall_if1); end
         #1;
         vecs++; if (mem_en1 !== 1'b0) begin errs++; $display("FAIL b2b_gap k%0d: got %b want 0", k, mem_en1); end
         tick();
         vecs++; if (if_valid1 !== 1'b1 || if_rdata1 !== datas[k]) begin errs++; $display("FAIL b2b_done k%0d: got v=%b data=%h want 1 %h", k, if_valid1, if_rdata1, datas[k]); end
         if (k < 2) begin
            if_addr1 = addrs[k+1];
            #1;
            vecs++; if (mem_en1 !== 1'b1 || mem_addr1 !== addrs[k+1]) begin errs++; $display("FAIL b2b_issue k%0d: got en=%b addr=%h want 1 %h", k + 1, mem_en1, mem_addr1, addrs[k+1]); end
         end else begin
            if_req1 = 1'b0;
         end
      end
      vecs++; if (d_valid1 !== 1'b0 || stall_mem1 !== 1'b0 || d_rdata1 !== 32'h0) begin errs++; $display("FAIL b2b_data_idle: got v=%b stall=%b data=%h want 0 0 0", d_valid1, stall_mem1, d_rdata1); end
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      if_req1 = 1'b0; if_addr1 = 32'h0;
      tick();
      test_reset();
      test_single_load();
      test_priority();
      test_store();
      test_kill();
      test_kill_edges();
      test_reset_mid();
      test_back_to_back_lat1();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
